// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch queue: fetches one word per cycle from a combinational IM
// into a DEPTH-entry circular buffer, with branch redirect flushing the queue.
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [4:0]               im_addr,
    input  logic [31:0]              im_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_ir,
    output logic [31:0]              out_pc_plus4,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_reg;
    logic [31:0]   pc_plus4;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [31:0]   ir_mem  [DEPTH];
    logic [31:0]   pc4_mem [DEPTH];
    logic          full;
    logic          push;
    logic          pop;

    assign pc_plus4  = fetch_pc_reg + 32'd4;
    assign im_addr   = fetch_pc_reg[6:2];
    assign full      = (count_reg == CW'(DEPTH));
    assign out_valid = (count_reg != '0) & !redirect;
    assign pop       = out_valid & out_ready;
    // A full queue can still accept the new word when the head leaves on the same edge.
    assign push      = !redirect & (!full | pop);
    assign out_ir       = ir_mem[rd_ptr_reg];
    assign out_pc_plus4 = pc4_mem[rd_ptr_reg];
    assign level        = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_reg <= RESET_PC;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
        end else if (redirect) begin
            count_reg    <= '0;
            rd_ptr_reg   <= wr_ptr_reg;
            fetch_pc_reg <= redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                fetch_pc_reg <= pc_plus4;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (reset) begin
                    ir_mem[gi]  <= '0;
                    pc4_mem[gi] <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    ir_mem[gi]  <= im_data;
                    pc4_mem[gi] <= pc_plus4;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a per-cycle vector table plus a
// back-pressure fill/drain sequence against a combinational IM model.
module tb_fetch_prefetch_unit;

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [4:0]  im_addr;
    logic [31:0] im_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [31:0] out_pc_plus4;
    logic [2:0]  level;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock        (clock),
        .reset        (reset),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .im_addr      (im_addr),
        .im_data      (im_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ir       (out_ir),
        .out_pc_plus4 (out_pc_plus4),
        .level        (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] im_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    assign im_data = 32'hC0DE_0000 | {27'd0, im_addr};

    typedef struct {
        logic        rst;
        logic        rdr;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [2:0]  e_level;
        logic [4:0]  e_addr;
        logic        chk;
        logic [31:0] e_ir;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rdr, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [2:0] el, input logic [4:0] ea,
                       input logic chk, input logic [31:0] eir, input logic [31:0] epc4);
        vec_t v;
        v.rst = rst; v.rdr = rdr; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = ev; v.e_level = el; v.e_addr = ea;
        v.chk = chk; v.e_ir = eir; v.e_pc4 = epc4;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;

        //  rst rdr rpc            rdy  valid lvl addr chk ir            pc4
        add(1, 0, 32'h0,         0,   0, 0, 0,  1, 32'h0,        32'h0);
        add(0, 0, 32'h0,         1,   0, 0, 0,  1, 32'h0,        32'h0);
        add(0, 0, 32'h0,         1,   1, 1, 1,  1, im_word(0),   32'd4);
        add(0, 0, 32'h0,         1,   1, 1, 2,  1, im_word(1),   32'd8);
        add(0, 0, 32'h0,         1,   1, 1, 3,  1, im_word(2),   32'd12);
        add(0, 0, 32'h0,         0,   1, 1, 4,  1, im_word(3),   32'd16);
        add(0, 0, 32'h0,         0,   1, 2, 5,  1, im_word(3),   32'd16);
        add(0, 0, 32'h0,         0,   1, 3, 6,  1, im_word(3),   32'd16);
        add(0, 0, 32'h0,         0,   1, 4, 7,  1, im_word(3),   32'd16);
        add(0, 0, 32'h0,         0,   1, 4, 7,  1, im_word(3),   32'd16);
        add(0, 0, 32'h0,         1,   1, 4, 7,  1, im_word(3),   32'd16);
        add(0, 0, 32'h0,         0,   1, 4, 8,  1, im_word(4),   32'd20);
        add(0, 0, 32'h0,         1,   1, 4, 8,  1, im_word(4),   32'd20);
        add(0, 0, 32'h0,         1,   1, 4, 9,  1, im_word(5),   32'd24);
        add(1, 0, 32'h0,         1,   1, 4, 10, 1, im_word(6),   32'd28);
        add(0, 0, 32'h0,         0,   0, 0, 0,  1, 32'h0,        32'h0);
        add(0, 0, 32'h0,         0,   1, 1, 1,  1, im_word(0),   32'd4);
        add(0, 0, 32'h0,         0,   1, 2, 2,  1, im_word(0),   32'd4);
        add(0, 1, 32'h0000_0043, 1,   0, 3, 3,  1, im_word(0),   32'd4);
        add(0, 0, 32'h0,         1,   0, 0, 16, 0, 32'h0,        32'h0);
        add(0, 0, 32'h0,         1,   1, 1, 17, 1, im_word(16),  32'h44);
        add(0, 1, 32'hFFFF_FFFC, 1,   0, 1, 18, 1, im_word(17),  32'h48);
        add(0, 1, 32'h0000_0011, 1,   0, 0, 31, 0, 32'h0,        32'h0);
        add(0, 1, 32'hFFFF_FFFF, 0,   0, 0, 4,  0, 32'h0,        32'h0);
        add(0, 0, 32'h0,         0,   0, 0, 31, 0, 32'h0,        32'h0);
        add(0, 0, 32'h0,         1,   1, 1, 0,  1, im_word(31),  32'h0);
        add(0, 0, 32'h0,         1,   1, 1, 1,  1, im_word(0),   32'd4);
        add(1, 1, 32'h0000_0080, 1,   0, 1, 2,  1, im_word(1),   32'd8);
        add(0, 0, 32'h0,         0,   0, 0, 0,  1, 32'h0,        32'h0);
        add(0, 0, 32'h0,         0,   1, 1, 1,  1, im_word(0),   32'd4);

        @(posedge clock);
        foreach (vecs[i]) begin
            @(negedge clock);
            reset = vecs[i].rst; redirect = vecs[i].rdr;
            redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
            #1;
            $display("vec %0d: rst=%0b rdr=%0b rdy=%0b valid=%0b level=%0d addr=%0d ir=%h pc4=%h",
                     i, reset, redirect, out_ready, out_valid, level, im_addr, out_ir, out_pc_plus4);
            check("out_valid", i, 32'(out_valid), 32'(vecs[i].e_valid));
            check("level",     i, 32'(level),     32'(vecs[i].e_level));
            check("im_addr",   i, 32'(im_addr),   32'(vecs[i].e_addr));
            if (vecs[i].chk) begin
                check("out_ir",       i, out_ir,       vecs[i].e_ir);
                check("out_pc_plus4", i, out_pc_plus4, vecs[i].e_pc4);
            end
        end

        // Back-pressure for 8 cycles, then drain: IM[0..5] in order with no gaps.
        @(negedge clock);
        reset = 1'b1; redirect = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            $display("stall %0d: valid=%0b level=%0d addr=%0d ir=%h", k, out_valid, level, im_addr, out_ir);
            check("stall_level", k, 32'(level),   (k < 4) ? 32'(k) : 32'd4);
            check("stall_addr",  k, 32'(im_addr), (k < 4) ? 32'(k) : 32'd4);
            if (k > 0) check("stall_ir", k, out_ir, im_word(0));
        end
        @(negedge clock);
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) @(negedge clock);
            #1;
            $display("drain %0d: valid=%0b level=%0d ir=%h pc4=%h", j, out_valid, level, out_ir, out_pc_plus4);
            check("drain_valid", j, 32'(out_valid), 32'd1);
            check("drain_ir",    j, out_ir,         im_word(j));
            check("drain_pc4",   j, out_pc_plus4,   32'(4 * (j + 1)));
            check("drain_level", j, 32'(level),     32'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, number of prefetch-queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, fetch PC loaded on reset; bits [1:0] zero.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 redirect  input  1  taken branch from the MEM stage; flushes the queue and reloads the PC.
REQ-006 redirect_pc  input  32  branch target; bits [1:0] ignored and treated as 00.
REQ-007 im_addr  output  5  word address to the combinational instruction memory, equal to fetch_pc[6:2].
REQ-008 im_data  input  32  instruction word returned by IM for im_addr in the same cycle.
REQ-009 out_valid  output  1  queue head holds a valid instruction.
REQ-010 out_ready  input  1  consumer (IF/ID register write enable) accepts the head this cycle.
REQ-011 out_ir  output  32  instruction at the queue head.
REQ-012 out_pc_plus4  output  32  PC+4 of the head instruction.
REQ-013 level  output  clog2(DEPTH)+1  current number of queued entries.

Function
REQ-014 Internal state: fetch_pc (32b), DEPTH-entry circular buffer of {ir, pc_plus4}, read pointer, write pointer, count.
REQ-015 pop = out_valid & out_ready; push = !redirect & (count < DEPTH | pop).
REQ-016 On push: buffer[wr] <= {im_data, fetch_pc+4}; wr advances; fetch_pc <= fetch_pc+4.
REQ-017 On pop: rd advances; head entry is discarded.
REQ-018 Pointers wrap modulo DEPTH; fetch_pc+4 wraps modulo 2^32 with no flag.
REQ-019 count next = count + push - pop; simultaneous push and pop when full keeps count = DEPTH.
REQ-020 No push when full without a pop: fetch_pc holds and IM output is ignored.
REQ-021 out_valid = (count != 0) & !redirect; out_ir and out_pc_plus4 are driven combinationally from buffer[rd].
REQ-022 Output values when out_valid = 0 are don't-care to the consumer but must not be X after reset.
REQ-023 A pop on an empty queue is impossible (out_valid = 0); out_ready is then ignored.
REQ-024 Redirect cycle: count <= 0, rd <= wr, fetch_pc <= {redirect_pc[31:2],2'b00}; no push and no pop that cycle.
REQ-025 The first target instruction is pushed on the edge after the redirect edge; out_valid rises one cycle after that.
REQ-026 Redirect has priority over push, pop and full conditions; consecutive redirects each reload fetch_pc.
REQ-027 Latency: instruction at fetch_pc reaches the head in 1 cycle when the queue is empty.
REQ-028 Throughput: 1 instruction per cycle while out_ready = 1.
REQ-029 Back-pressure: with out_ready = 0 the queue fills to DEPTH, then fetch stalls; head entry and its outputs are held stable.
REQ-030 level always equals count; it never exceeds DEPTH.

Reset
REQ-031 On a clock edge with reset = 1: fetch_pc <= RESET_PC, rd = wr = count = 0, all buffer entries <= 0.
REQ-032 After reset: out_valid = 0, level = 0, out_ir = 0, out_pc_plus4 = 0, im_addr = RESET_PC[6:2].
REQ-033 Reset overrides redirect, push and pop in the same cycle; reset mid-stall or mid-redirect discards all queued entries.
REQ-034 First push occurs on the first edge with reset = 0; out_valid = 1 in the following cycle with out_pc_plus4 = RESET_PC+4.

Verification
REQ-035 Reset, then out_ready = 1 held, IM[i] = i -> out_ir sequence 0,1,2,... one per cycle; out_pc_plus4 = 4,8,12,...; level stays 1.
REQ-036 out_ready = 0 for 8 cycles after reset -> level climbs 1..4 then holds 4; im_addr frozen at 4; out_ir = IM[0] stable; release -> IM[0..3] then IM[4], no loss or duplication.
REQ-037 Full queue, out_ready = 1 for one cycle -> pop and push on the same edge; level stays 4; next fetched word is IM[4].
REQ-038 Redirect = 1 with redirect_pc = 32'h0000_0043 while level = 3 -> out_valid = 0 that cycle; level = 0 next cycle; im_addr = 16; IM[16] appears at the head with out_pc_plus4 = 32'h44.
REQ-039 Redirect and reset asserted together in the same cycle -> reset wins; fetch_pc = RESET_PC; level = 0.
REQ-040 fetch_pc = 32'hFFFF_FFFC via redirect -> head out_pc_plus4 = 0; next im_addr = 0; no hang.
